// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg : constants shared by the RISC datapath selector blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package risc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   RISC_WIDTH = 16;

endpackage

`default_nettype wire

// File: rtl/risc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// risc_rr_arbiter : round-robin grant search with an owned rotation pointer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module risc_rr_arbiter
  import risc_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_IN-1:0] grant_o,
  output logic [SEL_W-1:0]  grant_idx_o,
  output logic              any_grant_o
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  // Search starts at ptr and wraps, so the first hit is the fairest candidate.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    int               j;
    found       = 1'b0;
    idx         = '0;
    j           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      idx = SEL_W'(j);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    any_grant_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx_o + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/risc_nto1_select_reg.sv
// ---------------------------------------------------------------------------
// risc_nto1_select_reg : registered N:1 selector, fixed or round-robin grant
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module risc_nto1_select_reg
  import risc_pkg::*;
#(
  parameter  int WIDTH  = RISC_WIDTH,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_src_q,   out_src_d;

  logic              can_load;
  logic              transfer;
  logic              grant_any;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_IN-1:0] grant_oh;
  logic [NUM_IN-1:0] fix_grant;
  logic [NUM_IN-1:0] rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [WIDTH-1:0]  mux_data;

  risc_rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (in_valid),
    .advance_i   (transfer && (mode == MODE_RR)),
    .grant_o     (rr_grant),
    .grant_idx_o (rr_idx),
    .any_grant_o (rr_any)
  );

  // An out-of-range sel matches no channel, leaving the fixed grant empty.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      fix_grant[i] = (sel == SEL_W'(i));
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign grant_any = (mode == MODE_RR) ? rr_any   : (|fix_grant);
  assign grant_oh  = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign grant_idx = (mode == MODE_RR) ? rr_idx   : sel;
  assign in_ready  = (grant_any && can_load) ? grant_oh : '0;
  assign transfer  = |(in_valid & in_ready);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

`default_nettype wire
